// File: rtl/reg_mem_arbiter.sv
// reg_mem_arbiter: two-port round-robin arbiter and sequencer in front of a
// single-port reg_mem. Each port issues one read or write per req/ack
// handshake. A command takes three cycles: the IDLE sampling cycle, one
// ACCESS cycle that drives the memory pins, and a DONE cycle with the ack.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN  port N command (held stable until ackN)
//   ackN                   one-cycle completion pulse for port N
//   rdataN                 last read data returned to port N
//   mem_addr/mem_data_in   registered address/write data to reg_mem
//   mem_wen                reg_mem write enable, only during ACCESS
//   mem_data_out           combinational read data from reg_mem
//   busy                   high whenever the sequencer is not idle
module reg_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                               state, state_nxt;
  logic [NUM_PORTS-1:0]                 port_req;
  cmd_t [NUM_PORTS-1:0]                 port_cmd;
  cmd_t                                 cmd_q;
  logic                                 cmd_id;
  logic                                 last_grant;
  logic                                 win;
  logic                                 grant_vld;
  logic [NUM_PORTS-1:0]                 hit;
  logic [NUM_PORTS-1:0]                 ack_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

  assign port_req    = {req1, req0};
  assign port_cmd[0] = {we0, addr0, wdata0};
  assign port_cmd[1] = {we1, addr1, wdata1};

  // Port 1 wins unless port 0 also asks and port 1 was granted last.
  assign grant_vld = |port_req;
  assign win       = port_req[1] & ~(port_req[0] & last_grant);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; rst gates wen so a reset edge never commits a write.
  always_comb begin
    mem_wen = 1'b0;
    busy    = (state != IDLE);
    if (state == ACCESS) mem_wen = cmd_q.we & ~rst;
  end

  // Command latch. The latched fields double as the memory pins, so they
  // only move on a new grant and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      cmd_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == IDLE && grant_vld) begin
      cmd_q      <= port_cmd[win];
      cmd_id     <= win;
      last_grant <= win;
    end
  end

  assign mem_addr    = cmd_q.addr;
  assign mem_data_in = cmd_q.wdata;

  // Per-port response: ack is set at the end of ACCESS and falls one cycle
  // later because hit is only true during ACCESS.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign hit[p] = (state == ACCESS) && (cmd_id == 1'(p));

    always_ff @(posedge clk) begin
      if (rst) begin
        ack_q[p]   <= 1'b0;
        rdata_q[p] <= '0;
      end else begin
        ack_q[p] <= hit[p];
        if (hit[p] && !cmd_q.we) rdata_q[p] <= mem_data_out;
      end
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign rdata0 = rdata_q[0];
  assign rdata1 = rdata_q[1];

endmodule

// File: tb/tb_reg_mem_arbiter.sv
module tb_reg_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_v [2];
  logic          we_v  [2];
  logic [AW-1:0] addr_v[2];
  logic [DW-1:0] wdata_v[2];
  logic          ack0, ack1, mem_wen, busy;
  logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          ack_a  [2];
  logic [DW-1:0] rdata_a[2];

  logic [DW-1:0] tb_mem [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  reg_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .we0(we_v[0]), .addr0(addr_v[0]), .wdata0(wdata_v[0]),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req_v[1]), .we1(we_v[1]), .addr1(addr_v[1]), .wdata1(wdata_v[1]),
    .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wen(mem_wen),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  assign ack_a[0]   = ack0;
  assign ack_a[1]   = ack1;
  assign rdata_a[0] = rdata0;
  assign rdata_a[1] = rdata1;

  // reg_mem stand-in: combinational read, write on the clock edge.
  assign mem_data_out = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wen) tb_mem[mem_addr] <= mem_data_in;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: once a command is granted it owns the memory for one
  // access cycle (timer=2) and is acknowledged in the following cycle (timer=1).
  int            m_timer = 0;
  int            m_win = 0;
  bit            m_last = 1'b1;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] ref_mem [32];

  function automatic int pick(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return last ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_timer  <= 0;
      m_last   <= 1'b1;
      m_rd[0]  <= '0;
      m_rd[1]  <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_we     <= 1'b0;
    end else if (m_timer == 0) begin
      if (req_v[0] || req_v[1]) begin
        m_win   <= pick(req_v[0], req_v[1], m_last);
        m_last  <= (pick(req_v[0], req_v[1], m_last) == 1);
        m_we    <= we_v[pick(req_v[0], req_v[1], m_last)];
        m_addr  <= addr_v[pick(req_v[0], req_v[1], m_last)];
        m_wdata <= wdata_v[pick(req_v[0], req_v[1], m_last)];
        m_timer <= 2;
      end
    end else if (m_timer == 2) begin
      if (m_we) ref_mem[m_addr] <= m_wdata;
      else      m_rd[m_win]     <= ref_mem[m_addr];
      m_timer <= 1;
    end else begin
      m_timer <= 0;
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    chk("busy",        int'(busy),        int'(m_timer != 0));
    chk("mem_wen",     int'(mem_wen),     int'(m_timer == 2 && m_we && !rst));
    chk("ack0",        int'(ack0),        int'(m_timer == 1 && m_win == 0));
    chk("ack1",        int'(ack1),        int'(m_timer == 1 && m_win == 1));
    chk("ack_excl",    int'(ack0 & ack1), 0);
    chk("rdata0",      int'(rdata0),      int'(m_rd[0]));
    chk("rdata1",      int'(rdata1),      int'(m_rd[1]));
    chk("mem_addr",    int'(mem_addr),    int'(m_addr));
    chk("mem_data_in", int'(mem_data_in), int'(m_wdata));
  end

  // Monitors used by the directed literal checks.
  int            wen_cnt = 0;
  int            ack0_cnt = 0;
  logic [AW-1:0] wen_addr;
  logic [DW-1:0] wen_data;
  int            ack_log[$];
  always @(negedge clk) begin
    if (mem_wen) begin
      wen_cnt++;
      wen_addr = mem_addr;
      wen_data = mem_data_in;
    end
    if (ack0) begin ack0_cnt++; ack_log.push_back(0); end
    if (ack1) ack_log.push_back(1);
  end

  // Called just after a rising edge; returns just after the edge ending the ack cycle.
  task automatic issue(input int p, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd,
                       output int ac);
    int n;
    req_v[p] = 1'b1; we_v[p] = w; addr_v[p] = a; wdata_v[p] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_a[p] && n < 20);
    if (n >= 20) chk($sformatf("ack%0d_timeout", p), 0, 1);
    rd = rdata_a[p];
    ac = cyc;
    // No sampling in the ack cycle; fields may wander freely.
    addr_v[p] = AW'($urandom); wdata_v[p] = DW'($urandom); we_v[p] = 1'($urandom);
    @(posedge clk); #1;
    req_v[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [DW-1:0] rd;
    int ac;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), rd, ac);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd, rd1;
    int ac, ac1, t0, wc, a0c, prev;
    for (int i = 0; i < 32; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
    end
    m_rd[0] = '0; m_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_rdata0", int'(rdata0), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);

    // 1: write then read from the other port
    wc = wen_cnt; t0 = cyc;
    issue(0, 1'b1, 5'd5, 8'h2A, rd, ac);
    chk("t1_latency", ac - t0, 2);
    chk("t1_wen_cycles", wen_cnt - wc, 1);
    chk("t1_wen_addr", int'(wen_addr), 5);
    chk("t1_wen_data", int'(wen_data), 'h2A);
    issue(1, 1'b0, 5'd5, 8'h00, rd, ac);
    chk("t1_rdata1", int'(rd), 'h2A);
    chk("t1_rdata0", int'(rdata0), 0);

    // 2: simultaneous requests right after reset, port 0 first
    do_reset();
    t0 = cyc;
    fork
      issue(0, 1'b1, 5'd3, 8'h11, rd, ac);
      issue(1, 1'b1, 5'd4, 8'h22, rd1, ac1);
    join
    chk("t2_p0_latency", ac - t0, 2);
    chk("t2_p1_after_p0", ac1 - ac, 3);
    issue(0, 1'b0, 5'd3, 8'h00, rd, ac);
    chk("t2_read3", int'(rd), 'h11);
    issue(1, 1'b0, 5'd4, 8'h00, rd, ac);
    chk("t2_read4", int'(rd), 'h22);

    // 3: continuous contention alternates grants (port 1 was granted last)
    ack_log.delete();
    fork
      begin
        logic [DW-1:0] r; int c;
        repeat (4) issue(0, 1'b0, 5'd3, 8'h00, r, c);
      end
      begin
        logic [DW-1:0] r; int c;
        repeat (4) issue(1, 1'b0, 5'd4, 8'h00, r, c);
      end
    join
    chk("t3_ack_count", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++)
      chk($sformatf("t3_order%0d", i), ack_log[i], i % 2);

    // 4: boundary addresses
    issue(1, 1'b1, 5'd31, 8'hFF, rd, ac);
    issue(1, 1'b1, 5'd0, 8'h01, rd, ac);
    issue(1, 1'b0, 5'd31, 8'h00, rd, ac);
    chk("t4_read31", int'(rd), 'hFF);
    issue(1, 1'b0, 5'd0, 8'h00, rd, ac);
    chk("t4_read0", int'(rd), 'h01);

    // 5: reset during ACCESS drops the write
    issue(0, 1'b1, 5'd7, 8'h10, rd, ac);
    a0c = ack0_cnt;
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 5'd7; wdata_v[0] = 8'h55;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_wen_in_reset", int'(mem_wen), 0);
    chk("t5_busy_access", int'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b0; req_v[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_no_ack0", ack0_cnt - a0c, 0);
    issue(0, 1'b0, 5'd7, 8'h00, rd, ac);
    chk("t5_read7", int'(rd), 'h10);

    // 6: lone port 0 back-to-back after it was granted last
    issue(0, 1'b1, 5'd9, 8'h5A, rd, ac);
    prev = ac;
    for (int i = 0; i < 3; i++) begin
      t0 = cyc;
      issue(0, 1'b0, 5'd9, 8'h00, rd, ac);
      chk($sformatf("t6_latency%0d", i), ac - t0, 2);
      chk($sformatf("t6_spacing%0d", i), ac - prev, 3);
      chk($sformatf("t6_rdata%0d", i), int'(rd), 'h5A);
      prev = ac;
    end

    // Random traffic from both ports against the model
    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
